// File: rtl/mem_bank_ws.sv
// Word-addressed data memory bank: per-byte write enables, WAIT_CYCLES wait states, ena/busy/valid handshake.
// Latency WAIT_CYCLES+2 cycles per access; requests are ignored while busy. MEM_ADDR_ERR_EN enables out-of-range flagging.
module mem_bank_ws #(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 16,
    parameter int                ADDR_W      = 32,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [DATA_W-1:0] RST_WORD    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [DATA_W/8-1:0]   sel_byte_i,
    input  logic                  ena_i,
    input  logic                  w_r_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  valid_o,
    output logic                  busy,
    output logic                  err_o
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam int         SEL_W     = DATA_W / 8;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              w_r_q, w_r_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              oor;

    assign idx = addr_q[IDX_W-1:0];

`ifdef MEM_ADDR_ERR_EN
    assign oor = |addr_q[ADDR_W-1:IDX_W];
`else
    // Upper address bits alias onto the bank when range checking is off.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[ADDR_W-1:IDX_W];
    assign oor            = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        w_r_d   = w_r_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        mem_d   = mem_q;

        case (state_q)
            ST_IDLE: begin
                if (ena_i) begin
                    addr_d  = addr_i;
                    wdata_d = data_i;
                    sel_d   = sel_byte_i;
                    w_r_d   = w_r_i;
                    busy_d  = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (oor) begin
                    err_d = 1'b1;
                    if (!w_r_q) begin
                        rdata_d = '0;
                    end
                end else if (w_r_q) begin
                    for (int b = 0; b < SEL_W; b++) begin
                        if (sel_q[b]) begin
                            mem_d[idx][b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                end else begin
                    rdata_d = mem_q[idx];
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            w_r_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_WORD;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            w_r_q   <= w_r_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign data_o  = rdata_q;
    assign valid_o = valid_q;
    assign busy    = busy_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_mem_bank_ws.sv
// Directed bench for mem_bank_ws: a zero-wait bank and a three-wait bank share stimulus buses.
module tb_mem_bank_ws;

    localparam logic [31:0] RST_W = 32'hA5A5_0F0F;
`ifdef MEM_ADDR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  sel = '0;
    logic        w_r = 1'b0;
    logic        ena0 = 1'b0;
    logic        ena3 = 1'b0;

    logic [31:0] data0, data3;
    logic        valid0, valid3, busy0, busy3, err0, err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bank_ws #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .WAIT_CYCLES(0), .RST_WORD(RST_W)) u_dut0 (
        .clk(clk), .rst(rst), .addr_i(addr), .data_i(data_in), .sel_byte_i(sel),
        .ena_i(ena0), .w_r_i(w_r), .data_o(data0), .valid_o(valid0), .busy(busy0), .err_o(err0)
    );

    mem_bank_ws #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .WAIT_CYCLES(3), .RST_WORD(RST_W)) u_dut3 (
        .clk(clk), .rst(rst), .addr_i(addr), .data_i(data_in), .sel_byte_i(sel),
        .ena_i(ena3), .w_r_i(w_r), .data_o(data3), .valid_o(valid3), .busy(busy3), .err_o(err3)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", tag, act, exp);
        end
    endtask

    // One complete access; checks busy after accept, latency, data_o and err_o at the valid cycle.
    task automatic run_acc(input bit d3, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, input string tag, input logic [31:0] exp_dat,
                           input logic exp_err);
        int n;
        bit got;
        @(negedge clk);
        addr = a; data_in = wd; sel = s; w_r = wr;
        if (d3) ena3 = 1'b1; else ena0 = 1'b1;
        @(posedge clk); #1;
        ena0 = 1'b0; ena3 = 1'b0;
        check_eq({tag, "_busy"}, d3 ? busy3 : busy0, 32'd1);
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (d3 ? valid3 : valid0) got = 1'b1;
        end
        check_eq({tag, "_lat"}, n, d3 ? 32'd4 : 32'd1);
        check_eq({tag, "_dat"}, d3 ? data3 : data0, exp_dat);
        check_eq({tag, "_err"}, d3 ? err3 : err0, exp_err);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_valid", valid0, 0);
        check_eq("rst_data", data0, 0);
        check_eq("rst_err", err0, 0);
        check_eq("rst_busy3", busy3, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset restores memory and clears outputs mid-access
        run_acc(0, 0, 3, 0, 4'h0, "rd3_init", RST_W, 0);
        run_acc(0, 1, 3, 32'h1234_5678, 4'hF, "wr3", RST_W, 0);
        run_acc(0, 0, 3, 0, 4'h0, "rd3_new", 32'h1234_5678, 0);
        @(negedge clk);
        addr = 3; w_r = 1'b0; ena0 = 1'b1;
        @(posedge clk); #1;
        ena0 = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", busy0, 0);
        check_eq("midrst_valid", valid0, 0);
        check_eq("midrst_data", data0, 0);
        @(negedge clk);
        rst = 1'b0;
        run_acc(0, 0, 3, 0, 4'h0, "rd3_after_rst", RST_W, 0);

        // Full write, partial lanes, empty lane mask
        run_acc(0, 1, 5, 32'hDEAD_BEEF, 4'hF, "wr5_full", RST_W, 0);
        run_acc(0, 0, 5, 0, 4'h0, "rd5_full", 32'hDEAD_BEEF, 0);
        run_acc(0, 1, 5, 32'h1122_3344, 4'b0101, "wr5_part", 32'hDEAD_BEEF, 0);
        run_acc(0, 0, 5, 0, 4'h0, "rd5_part", 32'hDE22_BE44, 0);
        run_acc(0, 1, 5, 32'h0000_0000, 4'h0, "wr5_nosel", 32'hDE22_BE44, 0);
        run_acc(0, 0, 5, 0, 4'h0, "rd5_nosel", 32'hDE22_BE44, 0);

        // Address 16 is out of range with checking on, aliases word 0 otherwise
        run_acc(0, 1, 16, 32'hFFFF_FFFF, 4'hF, "wr16", 32'hDE22_BE44, ERR_EN);
        run_acc(0, 0, 0, 0, 4'h0, "rd0_alias", ERR_EN ? RST_W : 32'hFFFF_FFFF, 0);
        run_acc(0, 0, 16, 0, 4'h0, "rd16", ERR_EN ? 32'h0 : 32'hFFFF_FFFF, ERR_EN);

        // Three wait states, ena held high across two accesses
        @(negedge clk);
        addr = 1; w_r = 1'b0; ena3 = 1'b1;
        @(posedge clk); #1;
        check_eq("ws_e0_busy", busy3, 1);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            check_eq("ws_wait_busy", busy3, 1);
            check_eq("ws_wait_valid", valid3, 0);
        end
        @(posedge clk); #1;
        check_eq("ws_e4_valid", valid3, 1);
        check_eq("ws_e4_busy", busy3, 0);
        check_eq("ws_e4_data", data3, RST_W);
        @(posedge clk); #1;
        check_eq("ws_e5_valid", valid3, 0);
        check_eq("ws_e5_busy", busy3, 1);
        ena3 = 1'b0;
        for (int e = 6; e <= 8; e++) begin
            @(posedge clk); #1;
            check_eq("ws_2nd_valid", valid3, 0);
        end
        @(posedge clk); #1;
        check_eq("ws_e9_valid", valid3, 1);
        @(posedge clk); #1;
        check_eq("ws_e10_valid", valid3, 0);
        check_eq("ws_e10_busy", busy3, 0);

        // Reset during the wait phase of a write drops it
        run_acc(1, 0, 2, 0, 4'h0, "rd2_pre", RST_W, 0);
        @(negedge clk);
        addr = 2; data_in = 32'h0BAD_F00D; sel = 4'hF; w_r = 1'b1; ena3 = 1'b1;
        @(posedge clk); #1;
        ena3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check_eq("wsrst_busy", busy3, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        run_acc(1, 0, 2, 0, 4'h0, "rd2_after_rst", RST_W, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
